// File: rtl/quad_stim_gen.sv
// Quadrature stimulus generator: emits N Gray-code phase transitions on a/b per accepted command.
// Optional contact-bounce injection is compiled in with `define QUAD_STIM_BOUNCE_EN.
module quad_stim_gen #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 8,
    parameter int BOUNCE_N = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    output logic                a,
    output logic                b,
    output logic                busy,
    output logic                done,
    output logic [7:0]          position
);

`ifdef QUAD_STIM_BOUNCE_EN
    localparam int BOUNCE_CYC = 2 * BOUNCE_N;
    localparam int BOUNCE_W   = $clog2(BOUNCE_CYC + 1);
    // Period must outlast the bounce burst so the next clean edge starts from a settled line.
    localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(BOUNCE_CYC + 1);
`else
    localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(1);
`endif

    localparam logic [COUNT_W-1:0]  CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0]  CNT_ONE  = COUNT_W'(1);
    localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                dir_r;
    logic [COUNT_W-1:0]  remaining_r;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] tick_r;
    logic                a_r;
    logic                b_r;
    logic [7:0]          position_r;
    logic                busy_r;
    logic                done_r;
    logic                ready_r;

    logic                accept_s;
    logic                step_s;
    logic [PERIOD_W-1:0] period_eff_s;
    logic [1:0]          phase_next_s;
    logic [1:0]          ab_next_s;
    logic [7:0]          pos_next_s;

`ifdef QUAD_STIM_BOUNCE_EN
    logic [BOUNCE_W-1:0] bounce_cnt_r;
    logic [1:0]          bounce_mask_r;
`endif

    // Up order is 00 -> 10 -> 11 -> 01 -> 00; down walks it backwards.
    function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic up);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = up ? 2'b10 : 2'b01;
            2'b10:   nxt = up ? 2'b11 : 2'b00;
            2'b11:   nxt = up ? 2'b01 : 2'b10;
            2'b01:   nxt = up ? 2'b00 : 2'b11;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign a         = a_r;
    assign b         = b_r;
    assign position  = position_r;

    // Handshake, period clamp and step strobe
    always_comb begin
        accept_s     = cmd_valid & ready_r;
        period_eff_s = cmd_period;
        if (cmd_period < PERIOD_MIN) begin
            period_eff_s = PERIOD_MIN;
        end else begin
            period_eff_s = cmd_period;
        end
        step_s = (state_r == ST_RUN) && (remaining_r != CNT_ZERO) && (tick_r == PER_ONE);
    end

    // Next phase lines and position, including optional bounce toggling
    always_comb begin
        phase_next_s = next_phase({a_r, b_r}, dir_r);
        ab_next_s    = {a_r, b_r};
        pos_next_s   = position_r;
        if (step_s) begin
            ab_next_s = phase_next_s;
            if (dir_r) begin
                pos_next_s = position_r + 8'd1;
            end else begin
                pos_next_s = position_r - 8'd1;
            end
        end else begin
`ifdef QUAD_STIM_BOUNCE_EN
            if (bounce_cnt_r != {BOUNCE_W{1'b0}}) begin
                ab_next_s = {a_r, b_r} ^ bounce_mask_r;
            end else begin
                ab_next_s = {a_r, b_r};
            end
`else
            ab_next_s = {a_r, b_r};
`endif
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A zero-step command passes through RUN for one cycle with nothing to emit.
                if (remaining_r == CNT_ZERO) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs and command datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ready_r     <= 1'b1;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            position_r  <= 8'd0;
            dir_r       <= 1'b0;
            remaining_r <= CNT_ZERO;
            period_r    <= PERIOD_MIN;
            tick_r      <= PERIOD_MIN;
        end else begin
            busy_r     <= (state_next_s == ST_RUN);
            done_r     <= (state_next_s == ST_DONE);
            ready_r    <= (state_next_s == ST_IDLE);
            {a_r, b_r} <= ab_next_s;
            position_r <= pos_next_s;
            if (accept_s) begin
                dir_r       <= cmd_dir;
                remaining_r <= cmd_steps;
                period_r    <= period_eff_s;
                tick_r      <= period_eff_s;
            end else if (step_s) begin
                remaining_r <= remaining_r - CNT_ONE;
                tick_r      <= period_r;
            end else if (state_r == ST_RUN) begin
                tick_r <= tick_r - PER_ONE;
            end else begin
                tick_r <= tick_r;
            end
        end
    end

`ifdef QUAD_STIM_BOUNCE_EN
    // Bounce burst: the line that just moved toggles for 2*BOUNCE_N cycles, ending settled
    always_ff @(posedge clk) begin
        if (reset) begin
            bounce_cnt_r  <= {BOUNCE_W{1'b0}};
            bounce_mask_r <= 2'b00;
        end else if (step_s) begin
            bounce_cnt_r  <= BOUNCE_W'(BOUNCE_CYC);
            bounce_mask_r <= {a_r, b_r} ^ phase_next_s;
        end else if (bounce_cnt_r != {BOUNCE_W{1'b0}}) begin
            bounce_cnt_r  <= bounce_cnt_r - BOUNCE_W'(1);
            bounce_mask_r <= bounce_mask_r;
        end else begin
            bounce_cnt_r  <= bounce_cnt_r;
            bounce_mask_r <= bounce_mask_r;
        end
    end
`endif

endmodule

// File: tb/tb_quad_stim_gen.sv
// Self-checking bench for quad_stim_gen (default build): directed literal checks plus
// randomized commands compared every cycle against a timeline-based reference model.
module tb_quad_stim_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [7:0]  cmd_steps;
    logic [15:0] cmd_period;
    logic        a;
    logic        b;
    logic        busy;
    logic        done;
    logic [7:0]  position;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a command is a timeline from its accept edge.
    int         cyc       = 0;
    bit         chk_en    = 1'b0;
    bit         m_active  = 1'b0;
    int         m_k       = 0;
    int         m_n       = 0;
    int         m_p       = 1;
    bit         m_dir     = 1'b0;
    int         base_idx  = 0;
    logic [7:0] base_pos  = 8'd0;
    logic [1:0] seq_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_stim_gen dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    initial forever #5 clk = ~clk;

    function automatic int wrap4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    // Model update on every rising edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (reset === 1'b1) begin
            m_active = 1'b0;
            base_idx = 0;
            base_pos = 8'd0;
        end else begin
            if (!m_active && cmd_valid === 1'b1) begin
                m_active = 1'b1;
                m_k      = cyc;
                m_n      = int'(cmd_steps);
                m_p      = (cmd_period == 16'd0) ? 1 : int'(cmd_period);
                m_dir    = cmd_dir;
            end
            if (m_active && (cyc - m_k) >= m_n * m_p + 2) begin
                base_idx = m_dir ? wrap4(base_idx + m_n) : wrap4(base_idx - m_n);
                base_pos = m_dir ? base_pos + 8'(m_n) : base_pos - 8'(m_n);
                m_active = 1'b0;
            end
        end
    end

    task automatic model_expect(output logic [1:0] e_ab, output logic [7:0] e_pos,
                                output logic e_busy, output logic e_done, output logic e_ready);
        int j;
        int t;
        if (!m_active) begin
            e_ab = seq_ab[base_idx]; e_pos = base_pos;
            e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
        end else begin
            j = cyc - m_k;
            t = j / m_p;
            if (t > m_n) t = m_n;
            e_ab    = seq_ab[m_dir ? wrap4(base_idx + t) : wrap4(base_idx - t)];
            e_pos   = m_dir ? base_pos + 8'(t) : base_pos - 8'(t);
            e_busy  = (j <= m_n * m_p);
            e_done  = (j == m_n * m_p + 1);
            e_ready = 1'b0;
        end
    endtask

    // Per-cycle comparison against the model
    initial forever begin
        logic [1:0] e_ab;
        logic [7:0] e_pos;
        logic       e_busy, e_done, e_ready;
        @(negedge clk);
        if (chk_en) begin
            model_expect(e_ab, e_pos, e_busy, e_done, e_ready);
            vectors++;
            if ({a, b} !== e_ab || position !== e_pos || busy !== e_busy ||
                done !== e_done || cmd_ready !== e_ready) begin
                miscompares++;
                $display("FAIL cycle_cmp cyc=%0d: got ab=%b pos=%0d busy=%b done=%b ready=%b, expected ab=%b pos=%0d busy=%b done=%b ready=%b",
                         cyc, {a, b}, position, busy, done, cmd_ready,
                         e_ab, e_pos, e_busy, e_done, e_ready);
            end
        end
    end

    task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready === 1'b1 && !m_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_lit("idle_wait", {7'd0, m_active}, 8'd0);
    endtask

    task automatic send(input logic d, input logic [7:0] s, input logic [15:0] p, output int k);
        cmd_dir = d; cmd_steps = s; cmd_period = p; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = cyc;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  seen_done;
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 8'd0; cmd_period = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_lit("rst_ab",    {6'd0, a, b},     8'h00);
        check_lit("rst_pos",   position,         8'd0);
        check_lit("rst_busy",  {7'd0, busy},     8'd0);
        check_lit("rst_done",  {7'd0, done},     8'd0);
        check_lit("rst_ready", {7'd0, cmd_ready}, 8'd1);
        reset = 1'b0;

        // Up 4 steps, period 3
        wait_idle();
        send(1'b1, 8'd4, 16'd3, k);
        at_edge(k + 3);  check_lit("up_t1", {6'd0, a, b}, 8'h02);
        at_edge(k + 6);  check_lit("up_t2", {6'd0, a, b}, 8'h03);
        at_edge(k + 9);  check_lit("up_t3", {6'd0, a, b}, 8'h01);
        at_edge(k + 12); check_lit("up_t4", {6'd0, a, b}, 8'h00);
        at_edge(k + 13); check_lit("up_done", {7'd0, done}, 8'd1);
        check_lit("up_pos", position, 8'd4);

        // Down 2 steps, period 0 clamps to 1
        wait_idle();
        send(1'b0, 8'd2, 16'd0, k);
        at_edge(k + 1); check_lit("dn_t1", {6'd0, a, b}, 8'h01);
        at_edge(k + 2); check_lit("dn_t2", {6'd0, a, b}, 8'h03);
        check_lit("dn_pos", position, 8'd2);
        at_edge(k + 3); check_lit("dn_done", {7'd0, done}, 8'd1);
        at_edge(k + 4); check_lit("dn_done_once", {7'd0, done}, 8'd0);

        // Zero-step command
        wait_idle();
        send(1'b1, 8'd0, 16'd5, k);
        check_lit("z_busy", {7'd0, busy}, 8'd1);
        at_edge(k + 1);
        check_lit("z_done", {7'd0, done}, 8'd1);
        check_lit("z_busy_off", {7'd0, busy}, 8'd0);
        check_lit("z_ab", {6'd0, a, b}, 8'h03);
        at_edge(k + 2); check_lit("z_ready", {7'd0, cmd_ready}, 8'd1);

        // Position wrap in both directions
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_idle();
        send(1'b0, 8'd1, 16'd1, k);
        at_edge(k + 1); check_lit("wrap_dn", position, 8'd255);
        wait_idle();
        send(1'b1, 8'd1, 16'd1, k);
        at_edge(k + 1); check_lit("wrap_up", position, 8'd0);

        // Reset in the middle of a command
        wait_idle();
        send(1'b1, 8'd10, 16'd2, k);
        at_edge(k + 4);
        check_lit("abort_pre_ab", {6'd0, a, b}, 8'h03);
        reset = 1'b1;
        at_edge(k + 5);
        check_lit("abort_ab",    {6'd0, a, b},     8'h00);
        check_lit("abort_pos",   position,         8'd0);
        check_lit("abort_ready", {7'd0, cmd_ready}, 8'd1);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check_lit("abort_no_done", {7'd0, seen_done}, 8'd0);

        // Randomized commands, inputs churned every cycle
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_dir   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) cmd_steps = 8'($urandom_range(200, 255));
            else                            cmd_steps = 8'($urandom_range(0, 5));
            cmd_period = 16'($urandom_range(0, 4));
        end
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
